// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-back, write-allocate L1 data cache.
// Hits are served combinationally in IDLE with no stall. A miss stalls the
// pipeline, writes back a dirty victim if there is one, then refills the
// line. The stalled request is looked up again in IDLE and hits there.
module dcache_direct_mapped #(
    parameter int NUM_LINES = 32,
    parameter int LINE_BITS = 256,
    parameter int ADDR_W    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADDR_W-1:0]    p1_addr_i,
    input  logic [31:0]          p1_data_i,
    input  logic                 p1_MemRead_i,
    input  logic                 p1_MemWrite_i,
    output logic [31:0]          p1_data_o,
    output logic                 p1_stall_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);
    localparam int OFF_W  = $clog2(LINE_BITS / 8);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int WSEL_W = $clog2(LINE_BITS / 32);

    typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, ALLOCATE, REFILL} state_t;

    state_t state, state_nxt;

    logic [TAG_W-1:0]     tags  [NUM_LINES];
    logic [LINE_BITS-1:0] lines [NUM_LINES];
    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;
    logic [LINE_BITS-1:0] fill;

    logic [IDX_W-1:0]     idx;
    logic [TAG_W-1:0]     tag;
    logic [WSEL_W-1:0]    wsel;
    logic [1:0]           unused_byte_sel;
    logic [LINE_BITS-1:0] cur_line;
    logic                 hit, req, wr, rd, serve;

    // Address split; the byte-within-word bits play no part in a word cache.
    assign idx             = p1_addr_i[OFF_W +: IDX_W];
    assign tag             = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign wsel            = p1_addr_i[2 +: WSEL_W];
    assign unused_byte_sel = p1_addr_i[1:0];

    assign cur_line = lines[idx];
    assign hit      = valid[idx] && (tags[idx] == tag);
    assign wr       = p1_MemWrite_i;
    assign rd       = p1_MemRead_i && !p1_MemWrite_i;   // store wins when both set
    assign req      = p1_MemRead_i || p1_MemWrite_i;
    assign serve    = req && hit && (state == IDLE);

    assign p1_stall_o = req && (!hit || state != IDLE);
    assign p1_data_o  = (serve && rd) ? cur_line[{wsel, 5'd0} +: 32] : 32'd0;

    // State register; reset abandons any memory transaction in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Line status bits: refill installs a clean line, a store hit marks it dirty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid <= '0;
            dirty <= '0;
        end else if (state == REFILL) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
        end else if (serve && wr) begin
            dirty[idx] <= 1'b1;
        end
    end

    // Tag/data arrays and the refill holding register (contents not reset).
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state == ALLOCATE && mem_ack_i) fill <= mem_data_i;
            if (state == REFILL) begin
                lines[idx] <= fill;
                tags[idx]  <= tag;
            end else if (serve && wr) begin
                lines[idx][{wsel, 5'd0} +: 32] <= p1_data_i;
            end
        end
    end

    // Next state and memory request; outputs depend on state only, so they
    // stay stable for the whole request while the pipeline holds its inputs.
    always_comb begin
        state_nxt    = state;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        case (state)
            IDLE: begin
                if (req && !hit) state_nxt = MISS;
            end
            MISS: begin
                if (valid[idx] && dirty[idx]) state_nxt = WRITEBACK;
                else                          state_nxt = ALLOCATE;
            end
            WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tags[idx], idx, {OFF_W{1'b0}}};
                mem_data_o   = cur_line;
                if (mem_ack_i) state_nxt = ALLOCATE;
            end
            ALLOCATE: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {tag, idx, {OFF_W{1'b0}}};
                if (mem_ack_i) state_nxt = REFILL;
            end
            REFILL: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Bench for dcache_direct_mapped: a line-wide memory responder with
// programmable ack latency, a word-level reference memory, and a queue of
// expected load results compared when each access completes.
module tb_dcache_direct_mapped;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  p1_addr, p1_wdata, p1_rdata;
    logic         p1_rd, p1_wr, stall;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata, mem_rdata;
    logic         mem_en, mem_we, mem_ack;

    int checks = 0;
    int errors = 0;

    // memory responder controls and observations
    int           lat_rd = 1, lat_wb = 1;
    bit           force_ack = 0;
    bit           saw_write = 0;
    int           fetch_cnt = 0, wb_cnt = 0;
    logic [31:0]  fetch_addr = 0, wb_addr = 0;
    logic [255:0] wb_data = 0;

    logic [31:0]  memw [logic [31:0]];   // memory contents, word-addressed
    logic [31:0]  refw [logic [31:0]];   // what the CPU should read back
    logic [31:0]  exp_q [$];

    dcache_direct_mapped dut (
        .clk_i(clk), .rst_i(rst),
        .p1_addr_i(p1_addr), .p1_data_i(p1_wdata),
        .p1_MemRead_i(p1_rd), .p1_MemWrite_i(p1_wr),
        .p1_data_o(p1_rdata), .p1_stall_o(stall),
        .mem_addr_o(mem_addr), .mem_data_o(mem_wdata),
        .mem_enable_o(mem_en), .mem_write_o(mem_we),
        .mem_data_i(mem_rdata), .mem_ack_i(mem_ack)
    );

    always #5 clk = ~clk;

    // Untouched memory: word at 0x400+4k reads 0xA000_0000+k.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        return 32'hA000_0000 + {2'b00, a[31:2]} - 32'h100;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] k;
        k = {a[31:2], 2'b00};
        if (memw.exists(k)) return memw[k];
        return init_word(k);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] k;
        k = {a[31:2], 2'b00};
        if (refw.exists(k)) return refw[k];
        return init_word(k);
    endfunction

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model: ack in the lat-th cycle of each request, sampled on negedges.
    initial begin
        int cnt;
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_en && mem_we) saw_write = 1;
            if (force_ack) begin
                mem_ack = 1'b1;
            end else if (mem_en && !rst) begin
                cnt++;
                if (cnt >= (mem_we ? lat_wb : lat_rd)) begin
                    cnt = 0;
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        wb_cnt++;
                        wb_addr = mem_addr;
                        wb_data = mem_wdata;
                        for (int k = 0; k < 8; k++)
                            memw[mem_addr + 32'(4 * k)] = mem_wdata[k*32 +: 32];
                    end else begin
                        fetch_cnt++;
                        fetch_addr = mem_addr;
                        for (int k = 0; k < 8; k++)
                            mem_rdata[k*32 +: 32] = mem_word(mem_addr + 32'(4 * k));
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // One CPU access, started on a negedge; counts stalled cycles and checks
    // the load result against the scoreboard in the cycle the hit is served.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int exp_stall);
        int n;
        bit done;
        p1_addr = a; p1_wdata = wd; p1_rd = rd; p1_wr = wr;
        if (wr) begin
            exp_q.push_back(32'd0);
            refw[{a[31:2], 2'b00}] = wd;
        end else begin
            exp_q.push_back(ref_word(a));
        end
        n = 0;
        done = 0;
        while (!done && n < 300) begin
            #1;
            if (!stall) done = 1;
            else begin
                n++;
                @(negedge clk);
            end
        end
        if (!done) chk({tag, " timeout"}, 256'(0), 256'(1));
        chk({tag, " stall"}, 256'(n), 256'(exp_stall));
        chk({tag, " data"}, 256'(p1_rdata), 256'(exp_q.pop_front()));
        @(negedge clk);
        p1_rd = 0; p1_wr = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, w0;
        rst = 1; p1_addr = 0; p1_wdata = 0; p1_rd = 0; p1_wr = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        chk("reset stall", 256'(stall), 256'(0));
        chk("reset data", 256'(p1_rdata), 256'(0));
        chk("reset mem_en", 256'(mem_en), 256'(0));
        chk("reset mem_we", 256'(mem_we), 256'(0));
        chk("reset mem_addr", 256'(mem_addr), 256'(0));
        chk("reset mem_data", mem_wdata, 256'(0));
        @(negedge clk);

        // cold read miss: ALLOCATE lasts 9 cycles; the stall also covers the
        // lookup cycle that detects the miss, MISS and REFILL
        lat_rd = 9;
        access("t1 cold", 1, 0, 32'h0000_0404, 0, 12);
        chk("t1 fetches", 256'(fetch_cnt), 256'(1));
        chk("t1 fetch addr", 256'(fetch_addr), 256'(32'h0000_0400));
        chk("t1 no wb", 256'(wb_cnt), 256'(0));

        // write hit then read-back
        access("t2 write", 0, 1, 32'h0000_0408, 32'hDEAD_BEEF, 0);
        access("t2 read", 1, 0, 32'h0000_0408, 0, 0);
        access("t2 word1", 1, 0, 32'h0000_0404, 0, 0);

        // dirty eviction: Lw=3, L=4
        lat_wb = 3; lat_rd = 4;
        f0 = fetch_cnt;
        access("t3 evict", 1, 0, 32'h0000_0808, 0, 3 + 4 + 3);
        chk("t3 wb count", 256'(wb_cnt), 256'(1));
        chk("t3 wb addr", 256'(wb_addr), 256'(32'h0000_0400));
        chk("t3 wb word2", 256'(wb_data[95:64]), 256'(32'hDEAD_BEEF));
        chk("t3 wb word1", 256'(wb_data[63:32]), 256'(32'hA000_0001));
        chk("t3 fetch addr", 256'(fetch_addr), 256'(32'h0000_0800));
        chk("t3 fetches", 256'(fetch_cnt - f0), 256'(1));

        // clean conflict ping-pong
        lat_rd = 2;
        saw_write = 0;
        f0 = fetch_cnt;
        for (int i = 0; i < 4; i++)
            access("t4 pingpong", 1, 0, (i % 2 == 0) ? 32'h0000_0000 : 32'h0000_0400, 0, 5);
        chk("t4 fetches", 256'(fetch_cnt - f0), 256'(4));
        chk("t4 no write", 256'(saw_write), 256'(0));

        // reset during ALLOCATE, then a stray ack
        lat_rd = 50;
        p1_addr = 32'h0000_1000; p1_rd = 1;
        for (int i = 0; i < 20 && !(mem_en && !mem_we); i++) @(negedge clk);
        chk("t5 in allocate", 256'(mem_en && !mem_we), 256'(1));
        rst = 1; p1_rd = 0;
        @(negedge clk);
        #1;
        chk("t5 mem_en after rst", 256'(mem_en), 256'(0));
        rst = 0;
        force_ack = 1;
        @(negedge clk);
        #2;
        force_ack = 0;
        @(negedge clk);
        #1;
        chk("t5 late ack mem_en", 256'(mem_en), 256'(0));
        chk("t5 late ack stall", 256'(stall), 256'(0));
        @(negedge clk);
        lat_rd = 2;
        f0 = fetch_cnt;
        access("t5 reread", 1, 0, 32'h0000_1000, 0, 5);
        chk("t5 refetch", 256'(fetch_cnt - f0), 256'(1));

        // read+write together on a hit acts as a store
        access("t6 rdwr", 1, 1, 32'h0000_1004, 32'h1234_5678, 0);
        access("t6 read", 1, 0, 32'h0000_1004, 0, 0);
        lat_wb = 2; lat_rd = 1;
        w0 = wb_cnt;
        access("t6 evict", 1, 0, 32'h0000_1404, 0, 2 + 1 + 3);
        chk("t6 wb count", 256'(wb_cnt - w0), 256'(1));
        chk("t6 wb addr", 256'(wb_addr), 256'(32'h0000_1000));
        chk("t6 wb word1", 256'(wb_data[63:32]), 256'(32'h1234_5678));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
